// File: rtl/snn_sched.sv
// Front-end scheduler for snn_core: unpacks a byte-streamed binary image into the
// 1-bit input-unit RAM, then hands the RAM to the core and reports its digit.
module snn_sched #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              ram_we,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              result_vld,
  output logic [3:0]        result_digit,
  output logic              busy,
  output logic              rx_drop
);
  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BC_W      = $clog2(NUM_BYTES + 1);

  typedef enum logic [2:0] {LOAD, UNPACK, START, RUN, REPORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [3:0]        result_q, result_d;
  logic              drop_q;

  logic last_bit, last_pix, drain, accept;

  assign last_bit = (bit_idx_q == 3'd7);
  assign last_pix = (pix_cnt_q == ADDR_W'(NUM_PIXELS - 1));
  // hold empties this cycle, so a simultaneous byte may refill it
  assign drain    = (state_q == UNPACK) && last_bit && !last_pix && hold_full_q;
  assign accept   = rx_rdy && (byte_cnt_q < BC_W'(NUM_BYTES)) &&
                    ((state_q == LOAD) || ((state_q == UNPACK) && (!hold_full_q || drain)));

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    result_d    = result_q;
    if (accept) byte_cnt_d = byte_cnt_q + BC_W'(1);
    case (state_q)
      LOAD: if (accept) begin
        shift_d   = rx_data;
        bit_idx_d = 3'd0;
        state_d   = UNPACK;
      end
      UNPACK: begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (!last_pix) pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        if (last_bit) begin
          if (last_pix) begin
            state_d = START;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            if (accept) begin
              hold_d      = rx_data;
              hold_full_d = 1'b1;
            end
          end else if (accept) begin
            // byte arriving exactly at the boundary goes straight to the shifter
            shift_d = rx_data;
          end else begin
            state_d = LOAD;
          end
        end else if (accept) begin
          hold_d      = rx_data;
          hold_full_d = 1'b1;
        end
      end
      START: state_d = RUN;
      RUN: if (core_done) begin
        result_d = core_digit;
        state_d  = REPORT;
      end
      REPORT: begin
        pix_cnt_d  = '0;
        byte_cnt_d = '0;
        state_d    = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      pix_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      result_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      result_q    <= result_d;
      drop_q      <= rx_rdy && !accept;
    end
  end

  assign ram_we       = (state_q == UNPACK);
  assign ram_d        = ram_we & shift_q[bit_idx_q];
  assign ram_addr     = ((state_q == LOAD) || (state_q == UNPACK)) ? pix_cnt_q : core_addr;
  assign core_start   = (state_q == START);
  assign result_vld   = (state_q == REPORT);
  assign result_digit = result_q;
  assign busy         = (state_q != LOAD);
  assign rx_drop      = drop_q;
endmodule

// File: tb/tb_snn_sched.sv
// Directed bench for snn_sched: image load, hold/drop, core handoff, reset abort.
module tb_snn_sched;
  logic       clk = 1'b0, rst_n = 1'b1, rx_rdy = 1'b0, core_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [9:0] core_addr = '0, ram_addr;
  logic [3:0] core_digit = '0, result_digit;
  logic       ram_d, ram_we, core_start, result_vld, busy, rx_drop;

  int checks = 0, failures = 0;
  int cyc = 0, we_cnt = 0, start_cnt = 0, start_cyc = 0, last_we = 0, drop_cnt = 0, vld_cnt = 0;
  logic ram [0:1023];
  int   we_cyc [0:1023];

  snn_sched dut (.clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .core_addr(core_addr),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .result_vld(result_vld), .result_digit(result_digit), .busy(busy), .rx_drop(rx_drop));

  always #5 clk = ~clk;

  // external RAM model and event counters, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_we) begin
      ram[ram_addr] = ram_d;
      we_cyc[ram_addr] = cyc;
      we_cnt = we_cnt + 1;
      last_we = cyc;
    end
    if (core_start) begin start_cnt = start_cnt + 1; start_cyc = cyc; end
    if (rx_drop) drop_cnt = drop_cnt + 1;
    if (result_vld) vld_cnt = vld_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_rdy = 1'b1; rx_data = b;
    @(negedge clk); rx_rdy = 1'b0;
  endtask

  function automatic logic [7:0] img_byte(input int k);
    return 8'((k * 37 + 8'h3C) & 8'hFF);
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ram_we, ram_d, core_start, result_vld, busy, rx_drop} !== 6'b0) begin
      failures++; $display("FAIL reset_ctl got=%b want=000000", {ram_we, ram_d, core_start, result_vld, busy, rx_drop});
    end
    checks++;
    if (ram_addr !== 10'd0 || result_digit !== 4'd0) begin
      failures++; $display("FAIL reset_data addr=%0d digit=%0d want 0/0", ram_addr, result_digit);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_image();
    int we0 = we_cnt, st0 = start_cnt, dr0 = drop_cnt, errs = 0, t = 0;
    logic [7:0] a5 = 8'hA5;
    for (int k = 0; k < 98; k++) begin
      send_byte(8'hA5);
      if (k < 97) repeat (9) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    send_byte(8'h5A);  // 99th byte, arrives while the last byte unpacks
    while (start_cnt == st0 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 784; i++) if (ram[i] !== a5[i % 8]) errs++;
    checks++;
    if (errs != 0) begin failures++; $display("FAIL a5_ram bad_bits=%0d want 0", errs); end
    checks++;
    if (we_cnt - we0 != 784) begin failures++; $display("FAIL a5_we_count got=%0d want 784", we_cnt - we0); end
    checks++;
    if (start_cnt - st0 != 1) begin failures++; $display("FAIL a5_start_pulses got=%0d want 1", start_cnt - st0); end
    checks++;
    if (start_cyc != last_we + 1) begin failures++; $display("FAIL a5_start_latency got=%0d want 1", start_cyc - last_we); end
    checks++;
    if (drop_cnt - dr0 != 1) begin failures++; $display("FAIL byte99_drop got=%0d want 1", drop_cnt - dr0); end
    checks++;
    if (busy !== 1'b1 || core_start !== 1'b0) begin
      failures++; $display("FAIL run_state busy=%b start=%b want 1/0", busy, core_start);
    end
  endtask

  task automatic test_run_sweep();
    int errs = 0, we0 = we_cnt, dr0 = drop_cnt, v0 = vld_cnt;
    for (int a = 0; a < 784; a++) begin
      @(negedge clk); core_addr = 10'(a);
      #1 if (ram_addr !== 10'(a) || ram_we !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) begin failures++; $display("FAIL run_addr_sweep bad=%0d want 0", errs); end
    send_byte(8'hFF);
    repeat (2) @(negedge clk);
    checks++;
    if (drop_cnt - dr0 != 1 || we_cnt != we0) begin
      failures++; $display("FAIL run_byte_drop drops=%0d writes=%0d want 1/0", drop_cnt - dr0, we_cnt - we0);
    end
    @(negedge clk); core_done = 1'b1; core_digit = 4'd7;
    @(negedge clk); core_done = 1'b0; core_digit = 4'd0;
    #1;
    checks++;
    if (result_vld !== 1'b1 || result_digit !== 4'd7) begin
      failures++; $display("FAIL report vld=%b digit=%0d want 1/7", result_vld, result_digit);
    end
    @(negedge clk); #1;
    checks++;
    if (result_vld !== 1'b0 || busy !== 1'b0 || vld_cnt - v0 != 1) begin
      failures++; $display("FAIL post_report vld=%b busy=%b pulses=%0d want 0/0/1", result_vld, busy, vld_cnt - v0);
    end
  endtask

  task automatic test_done_in_load();
    int v0 = vld_cnt;
    @(negedge clk); core_done = 1'b1; core_digit = 4'd3;
    @(negedge clk); core_done = 1'b0; core_digit = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (vld_cnt != v0 || result_digit !== 4'd7 || busy !== 1'b0) begin
      failures++; $display("FAIL done_in_load pulses=%0d digit=%0d busy=%b want 0/7/0", vld_cnt - v0, result_digit, busy);
    end
  endtask

  task automatic test_back_to_back();
    int we0 = we_cnt, dr0 = drop_cnt, errs = 0;
    logic [15:0] exp16 = 16'h8001;
    @(negedge clk); rx_rdy = 1'b1; rx_data = 8'h01;
    @(negedge clk); rx_data = 8'h80;
    @(negedge clk); rx_data = 8'hFF;
    @(negedge clk); rx_rdy = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 16; i++) if (ram[i] !== exp16[i]) errs++;
    checks++;
    if (errs != 0) begin failures++; $display("FAIL b2b_ram bad_bits=%0d want 0", errs); end
    checks++;
    if (we_cnt - we0 != 16) begin failures++; $display("FAIL b2b_we_count got=%0d want 16", we_cnt - we0); end
    checks++;
    if (we_cyc[15] - we_cyc[0] != 15) begin failures++; $display("FAIL b2b_no_gap span=%0d want 15", we_cyc[15] - we_cyc[0]); end
    checks++;
    if (drop_cnt - dr0 != 1) begin failures++; $display("FAIL b2b_drop got=%0d want 1", drop_cnt - dr0); end
  endtask

  task automatic test_reset_mid();
    int we0, st0, errs = 0, t = 0;
    logic [7:0] b;
    for (int k = 0; k < 38; k++) begin  // 2 bytes already held from the previous test
      send_byte(8'hC3);
      if (k < 37) repeat (9) @(negedge clk);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, busy, core_start, result_vld, rx_drop} !== 5'b0 || ram_addr !== 10'd0 || result_digit !== 4'd0) begin
      failures++; $display("FAIL mid_reset we=%b busy=%b addr=%0d digit=%0d want all 0", ram_we, busy, ram_addr, result_digit);
    end
    @(negedge clk); rst_n = 1'b1;
    we0 = we_cnt; st0 = start_cnt;
    for (int k = 0; k < 98; k++) begin
      send_byte(img_byte(k));
      repeat (7) @(negedge clk);
    end
    while (start_cnt == st0 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 784; i++) begin
      b = img_byte(i / 8);
      if (ram[i] !== b[i % 8]) errs++;
    end
    checks++;
    if (errs != 0 || ram[0] !== 1'b0) begin failures++; $display("FAIL new_image_ram bad_bits=%0d ram0=%b want 0/0", errs, ram[0]); end
    checks++;
    if (we_cnt - we0 != 784 || start_cnt - st0 != 1) begin
      failures++; $display("FAIL new_image_counts writes=%0d starts=%0d want 784/1", we_cnt - we0, start_cnt - st0);
    end
    checks++;
    if (start_cyc != last_we + 1) begin failures++; $display("FAIL new_image_latency got=%0d want 1", start_cyc - last_we); end
    @(negedge clk); core_done = 1'b1; core_digit = 4'd2;
    @(negedge clk); core_done = 1'b0;
    #1;
    checks++;
    if (result_vld !== 1'b1 || result_digit !== 4'd2) begin
      failures++; $display("FAIL new_image_report vld=%b digit=%0d want 1/2", result_vld, result_digit);
    end
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_run_sweep();
    test_done_in_load();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snn_sched.md
Name: snn_sched

Overview:
- Front-end scheduler for snn_core.
- Receives a packed 784-pixel binary image as a byte stream from the UART receiver and unpacks it bit-serially into the 1-bit input-unit RAM.
- Hands RAM address ownership to snn_core, pulses start, waits for done, and latches/reports the classified digit.
- Owns the single input-unit RAM port and arbitrates it between the loader and the core by state.

Parameters:
- NUM_PIXELS, 784, pixels per image (must be a multiple of 8).
- ADDR_W, 10, input-unit RAM address width.
- NUM_BYTES, NUM_PIXELS/8 (98), bytes per image; derived, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_rdy  in  1  one-cycle pulse: new byte valid on rx_data.
- rx_data  in  8  received byte; bit0 = lowest-numbered pixel.
- ram_addr  out  ADDR_W  input-unit RAM address.
- ram_d  out  1  input-unit RAM write data.
- ram_we  out  1  input-unit RAM write enable.
- core_addr  in  ADDR_W  addr_input_unit driven by snn_core.
- core_start  out  1  one-cycle start pulse to snn_core.
- core_done  in  1  snn_core done pulse.
- core_digit  in  4  snn_core digit; valid while core_done=1.
- result_vld  out  1  one-cycle pulse: result_digit updated.
- result_digit  out  4  last classified digit (held).
- busy  out  1  high in every state except LOAD.
- rx_drop  out  1  one-cycle pulse: an rx_rdy byte was discarded.

Behaviour:
- Clocking and reset: single clock; reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0. State = LOAD. pix_cnt, byte_cnt, shift register and hold register cleared; hold_full = 0.
- Reset mid-operation aborts any partial image. The core is not notified.
- States:
  - LOAD: idle/await byte.
  - UNPACK: write 8 bits.
  - START: core_start=1 for exactly one cycle.
  - RUN: wait for core_done.
  - REPORT: result_vld=1 for exactly one cycle.
- Byte acceptance:
  - An rx_rdy is accepted only if byte_cnt < NUM_BYTES and the state is LOAD, or UNPACK with hold empty. byte_cnt increments on each accept.
  - Every other rx_rdy pulses rx_drop on the next cycle. This covers hold full, START, RUN, REPORT, and byte_cnt = NUM_BYTES.
- LOAD with an accepted byte: load the shift register, bit_idx = 0, go to UNPACK.
- UNPACK, per cycle: ram_we = 1, ram_addr = pix_cnt, ram_d = shift[bit_idx]; then pix_cnt++ and bit_idx++.
- After bit 7 (bit_idx = 7):
  - If pix_cnt was NUM_PIXELS-1, go to START.
  - Else if hold_full: move hold into the shift register, clear hold_full, stay in UNPACK. No gap cycle.
  - Else go to LOAD.
- Simultaneous rx_rdy and hold drain in the same cycle: the new byte lands in hold. No drop.
- Latency: byte accepted at cycle t → bit k written at t+1+k. Last pixel written at T → core_start at T+1 → RUN at T+2.
- RAM ownership:
  - ram_addr = pix_cnt in LOAD and UNPACK; core_addr in START, RUN and REPORT.
  - ram_we = 0 outside UNPACK.
  - ram_d = 0 when ram_we = 0.
- RUN: on core_done, result_digit <= core_digit and go to REPORT. result_vld is high in the cycle after core_done.
- core_done outside RUN is ignored.
- REPORT → LOAD; clear pix_cnt and byte_cnt.
- pix_cnt range is 0..NUM_PIXELS-1. It never wraps within an image and is cleared only in REPORT or on reset.

Test Plan:
- Reset, then 98 bytes of 0xA5 at 10-cycle spacing:
  - RAM[8k+i] = bit i of 0xA5 for all k.
  - ram_we high for exactly 784 cycles.
  - core_start single pulse 1 cycle after the final write.
- Back-to-back rx_rdy on consecutive cycles (0x01, 0x80, 0xFF):
  - First byte unpacks; second byte goes to hold; third is dropped.
  - rx_drop pulses once.
  - RAM[0..15] = 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1 with no gap cycle between bytes.
- RUN with core_addr sweep 0..783:
  - ram_addr tracks core_addr, ram_we = 0.
  - core_done with core_digit = 7 → result_vld one cycle later, result_digit = 7, busy = 0 the cycle after.
- Byte sent during RUN and a 99th byte: each produces an rx_drop pulse; RAM contents unchanged.
- core_done pulse while in LOAD: ignored; result_vld stays 0; result_digit holds its prior value.
- rst_n asserted after 40 bytes: outputs 0 immediately; a fresh 98-byte image then completes normally with RAM[0] from the new first byte.
